// File: rtl/lu_arbiter.sv
// Round-robin arbiter/sequencer feeding one shared WIDTH-bit OR/NOR logic unit.
// Optional per-requester completion counters are enabled with LU_ARB_STATS_EN.
module lu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             sel0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             sel1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] y,
    output logic             valid,
    output logic             owner,
    output logic             busy
`ifdef LU_ARB_STATS_EN
    ,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_q;
    logic             win_q;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sel_r;

    logic             pick;
    logic             cap_en;
    logic             exec_en;
    logic             done_en;
    logic [WIDTH-1:0] lu;

    // Handshake: a requester holds req and its operands stable until it sees its
    // one-cycle gnt; operands are captured on the edge that launches gnt, so any
    // req still high afterwards is treated as a fresh request once back in IDLE.
    always_comb begin
        state_d = state_q;
        pick    = 1'b0;
        cap_en  = 1'b0;
        exec_en = 1'b0;
        done_en = 1'b0;
        if (req0 && req1) begin
            pick = ~last_q;
        end else begin
            pick = req1;
        end
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    cap_en  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_en = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_en = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign lu   = sel_r ? (a_r | b_r) : ~(a_r | b_r);
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            sel_r   <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            valid   <= 1'b0;
            y       <= '0;
            owner   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt0    <= cap_en & ~pick;
            gnt1    <= cap_en & pick;
            valid   <= exec_en;
            if (cap_en) begin
                win_q <= pick;
                a_r   <= pick ? a1 : a0;
                b_r   <= pick ? b1 : b0;
                sel_r <= pick ? sel1 : sel0;
            end
            if (exec_en) begin
                y     <= lu;
                owner <= win_q;
            end
            // Priority rotates only when an operation actually completes.
            if (done_en) begin
                last_q <= owner;
            end
        end
    end

`ifdef LU_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else if (valid) begin
            if (!owner && cnt0 != 8'hff) begin
                cnt0 <= cnt0 + 8'd1;
            end
            if (owner && cnt1 != 8'hff) begin
                cnt1 <= cnt1 + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lu_arbiter.sv
// Self-checking bench for lu_arbiter: directed steps plus a randomized phase,
// checked every cycle against a timeline/queue reference model.
module tb_lu_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1, sel0, sel1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, valid, owner, busy;
    logic [W-1:0] y;
`ifdef LU_ARB_STATS_EN
    logic [7:0]   cnt0, cnt1;
`endif

    lu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .sel0(sel0),
        .req1(req1), .a1(a1), .b1(b1), .sel1(sel1),
        .gnt0(gnt0), .gnt1(gnt1), .y(y), .valid(valid), .owner(owner), .busy(busy)
`ifdef LU_ARB_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycle numbers of the scheduled grant/valid, expected results queue.
    int           cyc     = 0;
    int           free_at = 0;
    int           g_cyc   = -1;
    int           v_cyc   = -1;
    bit           mlast   = 1'b1;
    bit           gw      = 1'b0;
    logic [W-1:0] mdl_y   = '0;
    logic         mdl_owner = 1'b0;
    int           mcnt0 = 0;
    int           mcnt1 = 0;
    logic [W-1:0] exp_q[$];

    function automatic logic [W-1:0] lu_ref(logic [W-1:0] a, logic [W-1:0] b, logic s);
        logic [W-1:0] o;
        o = a | b;
        return s ? o : ~o;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: model consumes the inputs seen at the rising edge, outputs checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            free_at   = cyc + 1;
            mlast     = 1'b1;
            g_cyc     = -1;
            v_cyc     = -1;
            exp_q.delete();
            mdl_y     = '0;
            mdl_owner = 1'b0;
            mcnt0     = 0;
            mcnt1     = 0;
        end else begin
            if (cyc == v_cyc) begin
                if (!gw && mcnt0 < 255) mcnt0++;
                if (gw && mcnt1 < 255) mcnt1++;
            end
            if (cyc >= free_at && (req0 || req1)) begin
                gw = (req0 && req1) ? !mlast : req1;
                exp_q.push_back(gw ? lu_ref(a1, b1, sel1) : lu_ref(a0, b0, sel0));
                g_cyc   = cyc + 1;
                v_cyc   = cyc + 2;
                free_at = cyc + 3;
                mlast   = gw;
            end
        end
        cyc++;
        @(negedge clk);
        if (cyc == v_cyc && exp_q.size() > 0) begin
            mdl_y     = exp_q.pop_front();
            mdl_owner = gw;
        end
        chk("gnt0", gnt0, (cyc == g_cyc) && !gw);
        chk("gnt1", gnt1, (cyc == g_cyc) && gw);
        chk("valid", valid, cyc == v_cyc);
        chk("busy", busy, (cyc == g_cyc) || (cyc == v_cyc));
        chk("y", y, mdl_y);
        chk("owner", owner, mdl_owner);
`ifdef LU_ARB_STATS_EN
        chk("cnt0", cnt0, mcnt0);
        chk("cnt1", cnt1, mcnt1);
`endif
    endtask

    // Present one request, hold until granted, then release and run to the following IDLE.
    task automatic do_op(bit who, logic [W-1:0] a, logic [W-1:0] b, logic s);
        bit seen;
        if (who) begin req1 = 1'b1; a1 = a; b1 = b; sel1 = s; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; sel0 = s; end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = who ? gnt1 : gnt0;
        end
        chk("op_granted", seen, 1'b1);
        if (who) req1 = 1'b0; else req0 = 1'b0;
        tick();
        chk("op_valid", valid, 1'b1);
        tick();
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; sel0 = 1'b0; sel1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        @(negedge clk);

        // Reset with both requests held; first grant afterwards goes to requester 0.
        req0 = 1'b1; req1 = 1'b1;
        a0 = 4'b1010; b0 = 4'b0001; sel0 = 1'b1;
        do_reset(2);
        chk("rst_y", y, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        tick();
        chk("first_gnt0", gnt0, 1'b1);
        chk("first_gnt1", gnt1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

        // Single requester, OR then NOR.
        do_reset(1);
        req0 = 1'b1; a0 = 4'b0101; b0 = 4'b0011; sel0 = 1'b1;
        tick();
        chk("single_gnt_latency", gnt0, 1'b1);
        req0 = 1'b0;
        tick();
        chk("single_or_valid", valid, 1'b1);
        chk("single_or_y", y, 4'b0111);
        chk("single_or_owner", owner, 1'b0);
        tick();
        do_op(1'b0, 4'b0101, 4'b0011, 1'b0);
        chk("single_nor_y", y, 4'b1000);

        // Contention: strict alternation starting with requester 0.
        do_reset(1);
        req0 = 1'b1; a0 = 4'b0101; b0 = 4'b0011; sel0 = 1'b1;
        req1 = 1'b1; a1 = 4'b0000; b1 = 4'b0000; sel1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cont_gnt_order", {gnt1, gnt0}, (k % 2) ? 2'b10 : 2'b01);
            tick();
            chk("cont_y", y, (k % 2) ? 4'b1111 : 4'b0111);
            chk("cont_owner", owner, k % 2);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

        // Request raised while busy is served right after the current op.
        req0 = 1'b1; a0 = 4'b0001; b0 = 4'b0010; sel0 = 1'b1;
        tick();
        chk("busy_gnt0", gnt0, 1'b1);
        req0 = 1'b0;
        req1 = 1'b1; a1 = 4'b0100; b1 = 4'b0000; sel1 = 1'b1;
        tick();
        chk("busy_first_y", y, 4'b0011);
        tick();
        chk("busy_idle_gap", gnt1, 1'b0);
        tick();
        chk("busy_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        tick();
        chk("busy_second_y", y, 4'b0100);
        tick();

        // Reset while requester 1's op is in EXEC.
        do_op(1'b0, 4'b0001, 4'b0001, 1'b1);
        req1 = 1'b1; a1 = 4'b0110; b1 = 4'b0000; sel1 = 1'b1;
        tick();
        chk("rexec_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rexec_no_valid", valid, 1'b0);
        chk("rexec_y", y, 4'b0000);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("rexec_gnt0", gnt0, 1'b1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if (!req0 || gnt0) begin
                req0 = ($urandom_range(0, 2) != 0);
                a0 = W'($urandom); b0 = W'($urandom); sel0 = 1'($urandom);
            end
            if (!req1 || gnt1) begin
                req1 = ($urandom_range(0, 2) != 0);
                a1 = W'($urandom); b1 = W'($urandom); sel1 = 1'($urandom);
            end
            reset = ($urandom_range(0, 59) == 0);
            tick();
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

`ifdef LU_ARB_STATS_EN
        do_reset(1);
        for (int k = 0; k < 3; k++) do_op(1'b0, W'($urandom), W'($urandom), 1'($urandom));
        do_op(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        tick();
        chk("stats_cnt0_3", cnt0, 8'd3);
        chk("stats_cnt1_1", cnt1, 8'd1);
        do_reset(1);
        for (int k = 0; k < 300; k++) do_op(1'b0, W'($urandom), W'($urandom), 1'($urandom));
        tick();
        chk("stats_cnt0_sat", cnt0, 8'd255);
        chk("stats_cnt1_zero", cnt1, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
